lpddr_port_arbiter: RTL and testbench

//  N-channel Avalon-MM arbiter that multiplexes several masters onto the single

---
 rtl/lpddr_arb_pkg.sv | 20 ++
 rtl/arb_pend_fifo.sv | 50 +++++
 rtl/lpddr_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_lpddr_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpddr_arb_pkg.sv
// Shared types for the LPDDR port arbiter: FSM states and the read-ownership entry.
package lpddr_arb_pkg;

    localparam int unsigned ARB_NUM_CH  = 2;
    localparam int unsigned ARB_BURST_W = 5;
    localparam int unsigned CH_W        = (ARB_NUM_CH > 1) ? $clog2(ARB_NUM_CH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWburst
    } arb_state_e;

    // One outstanding read burst: owning channel and its beat count (always >= 1).
    typedef struct packed {
        logic [CH_W-1:0]        id;
        logic [ARB_BURST_W-1:0] beats;
    } pend_entry_t;

endpackage

// File: rtl/arb_pend_fifo.sv
// Synchronous FIFO of pending read bursts; push and pop may occur in the same cycle.
module arb_pend_fifo
    import lpddr_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  pend_entry_t push_data,
    input  logic        pop,
    output pend_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    pend_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    // A push into a full FIFO is still safe when the head is leaving this cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/lpddr_port_arbiter.sv
// Round-robin Avalon-MM arbiter with write-burst locking and read-return routing.
module lpddr_port_arbiter
    import lpddr_arb_pkg::*;
#(
    parameter int unsigned NUM_CH     = ARB_NUM_CH,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 26,
    parameter int unsigned BURST_W    = ARB_BURST_W,
    parameter int unsigned PEND_DEPTH = 8
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_address,
    input  logic [NUM_CH-1:0]         ch_read,
    input  logic [NUM_CH-1:0]         ch_write,
    input  logic [NUM_CH*DATA_W-1:0]  ch_writedata,
    input  logic [NUM_CH*BURST_W-1:0] ch_burstcount,
    output logic [NUM_CH-1:0]         ch_waitrequest,
    output logic [DATA_W-1:0]         ch_readdata,
    output logic [NUM_CH-1:0]         ch_readdatavalid,
    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [DATA_W-1:0]         mem_writedata,
    output logic [BURST_W-1:0]        mem_burstcount,
    input  logic                      mem_waitrequest,
    input  logic [DATA_W-1:0]         mem_readdata,
    input  logic                      mem_readdatavalid,
    output logic                      err_orphan
);

    arb_state_e       state_q, state_d;
    logic [CH_W-1:0]  grant_q, grant_d, rr_ptr_q, rr_ptr_d, rr_next, winner, arb_idx;
    logic [BURST_W-1:0] wbeat_q, wbeat_d, rd_beat_q, rd_beat_d;
    logic             err_orphan_q, orphan_set, found;

    logic [ADDR_W-1:0]  addr_a  [NUM_CH];
    logic [DATA_W-1:0]  wdata_a [NUM_CH];
    logic [BURST_W-1:0] bc_a    [NUM_CH];
    logic [NUM_CH-1:0]  eligible;
    logic [BURST_W-1:0] sel_bc, sel_bc_eff;
    logic               sel_read, sel_write;

    pend_entry_t push_entry, fifo_head;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            addr_a[i]  = ch_address[i*ADDR_W +: ADDR_W];
            wdata_a[i] = ch_writedata[i*DATA_W +: DATA_W];
            bc_a[i]    = ch_burstcount[i*BURST_W +: BURST_W];
        end
    end

    assign eligible   = ch_write | (ch_read & {NUM_CH{~fifo_full}});
    assign sel_read   = ch_read[grant_q];
    assign sel_write  = ch_write[grant_q] & ~ch_read[grant_q];
    assign sel_bc     = bc_a[grant_q];
    assign sel_bc_eff = (sel_bc == '0) ? BURST_W'(1) : sel_bc;
    assign rr_next    = (32'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
    assign push_entry = '{id: grant_q, beats: sel_bc_eff};

    // Round-robin scan starting at rr_ptr_q.
    always_comb begin
        found   = 1'b0;
        winner  = rr_ptr_q;
        arb_idx = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            arb_idx = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
            if (!found && eligible[arb_idx]) begin
                found  = 1'b1;
                winner = arb_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        wbeat_d        = wbeat_q;
        fifo_push      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = addr_a[grant_q];
        mem_writedata  = wdata_a[grant_q];
        mem_burstcount = sel_bc_eff;
        ch_waitrequest = '1;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = winner;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                mem_read                = sel_read;
                mem_write               = sel_write;
                ch_waitrequest[grant_q] = mem_waitrequest;
                if (!mem_waitrequest && sel_read) begin
                    fifo_push = 1'b1;
                    rr_ptr_d  = rr_next;
                    state_d   = StIdle;
                end else if (!mem_waitrequest && sel_write) begin
                    if (sel_bc_eff > BURST_W'(1)) begin
                        wbeat_d = sel_bc_eff - 1'b1;
                        state_d = StWburst;
                    end else begin
                        rr_ptr_d = rr_next;
                        state_d  = StIdle;
                    end
                end
            end
            StWburst: begin
                mem_write               = sel_write;
                ch_waitrequest[grant_q] = mem_waitrequest;
                if (sel_write && !mem_waitrequest) begin
                    wbeat_d = wbeat_q - 1'b1;
                    if (wbeat_q == BURST_W'(1)) begin
                        rr_ptr_d = rr_next;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Return path: route each beat to the head owner, pop on its last beat.
    always_comb begin
        ch_readdatavalid = '0;
        fifo_pop         = 1'b0;
        rd_beat_d        = rd_beat_q;
        orphan_set       = 1'b0;
        if (mem_readdatavalid) begin
            if (fifo_empty) begin
                orphan_set = 1'b1;
            end else begin
                ch_readdatavalid[fifo_head.id] = 1'b1;
                if (rd_beat_q + 1'b1 == fifo_head.beats) begin
                    fifo_pop  = 1'b1;
                    rd_beat_d = '0;
                end else begin
                    rd_beat_d = rd_beat_q + 1'b1;
                end
            end
        end
    end

    assign ch_readdata = mem_readdata;
    assign err_orphan  = err_orphan_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            wbeat_q      <= '0;
            rd_beat_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            wbeat_q      <= wbeat_d;
            rd_beat_q    <= rd_beat_d;
            err_orphan_q <= err_orphan_q | orphan_set;
        end
    end

    arb_pend_fifo #(
        .DEPTH(PEND_DEPTH)
    ) u_pend_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_lpddr_port_arbiter.sv
// Directed self-checking bench for lpddr_port_arbiter (2 channels, 8-deep pending queue).
module tb_lpddr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [51:0] ch_address;
    logic [1:0]  ch_read, ch_write;
    logic [63:0] ch_writedata;
    logic [9:0]  ch_burstcount;
    logic [1:0]  ch_waitrequest, ch_readdatavalid;
    logic [31:0] ch_readdata;
    logic [25:0] mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata;
    logic [4:0]  mem_burstcount;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic        err_orphan;

    int checks = 0;
    int errors = 0;

    localparam logic [25:0] ADDR0 = 26'h0000a00;
    localparam logic [25:0] ADDR1 = 26'h0001100;

    always #5 clk = ~clk;

    lpddr_port_arbiter dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .ch_address       (ch_address),
        .ch_read          (ch_read),
        .ch_write         (ch_write),
        .ch_writedata     (ch_writedata),
        .ch_burstcount    (ch_burstcount),
        .ch_waitrequest   (ch_waitrequest),
        .ch_readdata      (ch_readdata),
        .ch_readdatavalid (ch_readdatavalid),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_burstcount   (mem_burstcount),
        .mem_waitrequest  (mem_waitrequest),
        .mem_readdata     (mem_readdata),
        .mem_readdatavalid(mem_readdatavalid),
        .err_orphan       (err_orphan)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ch_address = {ADDR1, ADDR0};
        ch_read = '0; ch_write = '0; ch_writedata = '0; ch_burstcount = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
        repeat (3) step();
        checks++;
        if ({ch_waitrequest, mem_read, mem_write, ch_readdatavalid, err_orphan} !== 7'b11_0_0_00_0) begin
            errors++;
            $display("FAIL reset_state: got wr=%b rd=%b wr=%b rdv=%b orphan=%b, want 11 0 0 00 0",
                     ch_waitrequest, mem_read, mem_write, ch_readdatavalid, err_orphan);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        checks++;
        if ({ch_waitrequest, mem_read, mem_write} !== 4'b11_0_0) begin
            errors++;
            $display("FAIL post_reset_idle: got waitreq=%b read=%b write=%b, want 11 0 0",
                     ch_waitrequest, mem_read, mem_write);
        end
    endtask

    task automatic test_rr_reads();
        logic [1:0]  exp_wr;
        logic [25:0] exp_addr;
        ch_burstcount = {5'd4, 5'd4};
        ch_read = 2'b11;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem_read !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle_gap[%0d]: got mem_read=%b, want 0", k, mem_read);
            end
            step();
            exp_wr = 2'b11;
            exp_wr[k % 2] = 1'b0;
            exp_addr = (k % 2 == 0) ? ADDR0 : ADDR1;
            checks++;
            if ({mem_read, ch_waitrequest, mem_address, mem_burstcount} !== {1'b1, exp_wr, exp_addr, 5'd4}) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got rd=%b waitreq=%b addr=%h bc=%0d, want 1 %b %h 4",
                         k, mem_read, ch_waitrequest, mem_address, mem_burstcount, exp_wr, exp_addr);
            end
            step();
        end
        ch_read = '0;
        mem_readdatavalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem_readdata = 32'h100 + i;
            #1;
            checks++;
            if ({ch_readdatavalid, ch_readdata} !== {2'b01 << ((i / 4) % 2), 32'h100 + i}) begin
                errors++;
                $display("FAIL rr_return[%0d]: got rdv=%b data=%h, want %b %h",
                         i, ch_readdatavalid, ch_readdata, 2'b01 << ((i / 4) % 2), 32'h100 + i);
            end
            step();
        end
        mem_readdatavalid = 1'b0;
    endtask

    task automatic test_wburst();
        int   beats = 0;
        int   cyc = 0;
        logic stall = 1'b1;
        ch_write = 2'b10;
        ch_burstcount = {5'd8, 5'd1};
        ch_writedata[63:32] = 32'h200;
        step();
        ch_read = 2'b01;
        while (beats < 8 && cyc < 40) begin
            mem_waitrequest = stall;
            #1;
            checks++;
            if ({mem_write, mem_read, ch_waitrequest, mem_writedata} !== {1'b1, 1'b0, stall, 1'b1, 32'h200 + beats}) begin
                errors++;
                $display("FAIL wburst_beat[%0d]: got wr=%b rd=%b waitreq=%b data=%h, want 1 0 %b1 %h",
                         beats, mem_write, mem_read, ch_waitrequest, mem_writedata, stall, 32'h200 + beats);
            end
            step();
            if (!stall) begin
                beats++;
                ch_writedata[63:32] = 32'h200 + beats;
            end
            stall = ~stall;
            cyc++;
        end
        checks++;
        if (beats != 8) begin
            errors++;
            $display("FAIL wburst_timeout: got %0d beats, want 8", beats);
        end
        ch_write = '0;
        mem_waitrequest = 1'b0;
        #1;
        checks++;
        if ({mem_write, mem_read, ch_waitrequest} !== 4'b0_0_11) begin
            errors++;
            $display("FAIL wburst_release_gap: got wr=%b rd=%b waitreq=%b, want 0 0 11",
                     mem_write, mem_read, ch_waitrequest);
        end
        step();
        checks++;
        if ({mem_read, ch_waitrequest, mem_address} !== {1'b1, 2'b10, ADDR0}) begin
            errors++;
            $display("FAIL wburst_next_grant: got rd=%b waitreq=%b addr=%h, want 1 10 %h",
                     mem_read, ch_waitrequest, mem_address, ADDR0);
        end
        step();
        ch_read = '0;
        mem_readdatavalid = 1'b1;
        mem_readdata = 32'h1234;
        #1;
        checks++;
        if (ch_readdatavalid !== 2'b01) begin
            errors++;
            $display("FAIL wburst_read_return: got rdv=%b, want 01", ch_readdatavalid);
        end
        step();
        mem_readdatavalid = 1'b0;
    endtask

    task automatic test_fifo_full();
        ch_burstcount = {5'd1, 5'd0};
        ch_read = 2'b01;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if ({mem_read, mem_burstcount, ch_waitrequest} !== {1'b1, 5'd1, 2'b10}) begin
                errors++;
                $display("FAIL fill_read[%0d]: got rd=%b bc=%0d waitreq=%b, want 1 1 10",
                         k, mem_read, mem_burstcount, ch_waitrequest);
            end
            step();
        end
        ch_write = 2'b10;
        ch_writedata[63:32] = 32'h55;
        step();
        checks++;
        if ({mem_write, mem_read, ch_waitrequest, mem_writedata} !== {1'b1, 1'b0, 2'b01, 32'h55}) begin
            errors++;
            $display("FAIL full_write_passes: got wr=%b rd=%b waitreq=%b data=%h, want 1 0 01 55",
                     mem_write, mem_read, ch_waitrequest, mem_writedata);
        end
        step();
        ch_write = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({mem_read, mem_write, ch_waitrequest} !== 4'b0_0_11) begin
                errors++;
                $display("FAIL full_read_stall[%0d]: got rd=%b wr=%b waitreq=%b, want 0 0 11",
                         k, mem_read, mem_write, ch_waitrequest);
            end
        end
        mem_readdatavalid = 1'b1;
        mem_readdata = 32'h300;
        #1;
        checks++;
        if ({ch_readdatavalid, ch_readdata, mem_read} !== {2'b01, 32'h300, 1'b0}) begin
            errors++;
            $display("FAIL full_first_return: got rdv=%b data=%h rd=%b, want 01 300 0",
                     ch_readdatavalid, ch_readdata, mem_read);
        end
        step();
        mem_readdatavalid = 1'b0;
        step();
        // Freed slot is re-used while another beat pops in the same cycle.
        mem_readdatavalid = 1'b1;
        mem_readdata = 32'h301;
        #1;
        checks++;
        if ({mem_read, ch_waitrequest, ch_readdatavalid} !== {1'b1, 2'b10, 2'b01}) begin
            errors++;
            $display("FAIL push_pop_same_cycle: got rd=%b waitreq=%b rdv=%b, want 1 10 01",
                     mem_read, ch_waitrequest, ch_readdatavalid);
        end
        step();
        ch_read = '0;
        for (int j = 2; j < 9; j++) begin
            mem_readdata = 32'h300 + j;
            #1;
            checks++;
            if (ch_readdatavalid !== 2'b01) begin
                errors++;
                $display("FAIL drain_return[%0d]: got rdv=%b, want 01", j, ch_readdatavalid);
            end
            step();
        end
        mem_readdatavalid = 1'b0;
        #1;
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL no_orphan_after_drain: got err_orphan=%b, want 0", err_orphan);
        end
    endtask

    task automatic test_orphan();
        mem_readdatavalid = 1'b1;
        mem_readdata = 32'hdead;
        #1;
        checks++;
        if ({ch_readdatavalid, err_orphan} !== 3'b00_0) begin
            errors++;
            $display("FAIL orphan_dropped: got rdv=%b err=%b, want 00 0", ch_readdatavalid, err_orphan);
        end
        step();
        mem_readdatavalid = 1'b0;
        repeat (3) step();
        checks++;
        if ({err_orphan, mem_read, mem_write} !== 3'b1_0_0) begin
            errors++;
            $display("FAIL orphan_sticky: got err=%b rd=%b wr=%b, want 1 0 0", err_orphan, mem_read, mem_write);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_cleared_by_reset: got err=%b, want 0", err_orphan);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_burst();
        ch_write = 2'b01;
        ch_burstcount = {5'd1, 5'd4};
        step();
        step();
        checks++;
        if ({mem_write, ch_waitrequest} !== 3'b1_10) begin
            errors++;
            $display("FAIL burst_started: got wr=%b waitreq=%b, want 1 10", mem_write, ch_waitrequest);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_write, mem_read, ch_waitrequest} !== 4'b0_0_11) begin
            errors++;
            $display("FAIL reset_mid_burst: got wr=%b rd=%b waitreq=%b, want 0 0 11",
                     mem_write, mem_read, ch_waitrequest);
        end
        ch_write = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rr_reads();
        test_wburst();
        test_fifo_full();
        test_orphan();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
